// File: rtl/tb_harness_ctrl.sv
// tb_harness_ctrl: sequences the DUT reset, captures its UART bytes into a show-ahead FIFO,
// counts LED changes and run cycles, and reports the exit code or a timeout.
module tb_harness_ctrl #(
    parameter int                 DATA_W     = 8,
    parameter int                 FIFO_DEPTH = 16,
    parameter int                 N_LED      = 1,
    parameter int                 RST_HOLD   = 10,
    parameter int unsigned        TIMEOUT    = 1000000,
    parameter logic [DATA_W-1:0]  EOT_CHAR   = 8'h04
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              dut_rst_n,
    input  logic              uart_wr_valid,
    input  logic [DATA_W-1:0] uart_wr_data,
    input  logic [N_LED-1:0]  led,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              overflow,
    output logic [15:0]       led_toggles,
    output logic [31:0]       cycle_count,
    output logic              done,
    output logic              timed_out,
    output logic [DATA_W-1:0] exit_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {HOLD, RUN, EXIT, DONE} state_t;

    state_t            r_state, w_next;
    logic [HW-1:0]     r_hold;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wp, r_rp;
    logic              r_ovf, r_to;
    logic [15:0]       r_tog;
    logic [31:0]       r_cyc;
    logic [DATA_W-1:0] r_ec;
    logic [N_LED-1:0]  r_led;

    logic w_active, w_tmo, w_empty, w_full, w_pop, w_eot, w_push_req, w_push;

    assign w_active   = (r_state == RUN) || (r_state == EXIT);
    assign w_tmo      = w_active && (TIMEOUT != 0) && (r_cyc == TIMEOUT);
    assign w_empty    = r_wp == r_rp;
    assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop      = !w_empty && rd_ready;
    assign w_eot      = uart_wr_valid && (uart_wr_data == EOT_CHAR);
    // a timing-out cycle discards its byte without touching overflow
    assign w_push_req = (r_state == RUN) && uart_wr_valid && !w_eot && !w_tmo;
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= HOLD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HOLD:    w_next = (r_hold == HW'(RST_HOLD - 1)) ? RUN : HOLD;
            RUN:     w_next = w_tmo ? DONE : (w_eot ? EXIT : RUN);
            EXIT:    w_next = (w_tmo || uart_wr_valid) ? DONE : EXIT;
            default: w_next = DONE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= uart_wr_data;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_hold <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_ovf  <= 1'b0;
            r_tog  <= '0;
            r_cyc  <= '0;
            r_to   <= 1'b0;
            r_ec   <= '0;
            r_led  <= '0;
        end else begin
            r_led <= led;
            if (r_state == HOLD) r_hold <= r_hold + 1'b1;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_active && (led != r_led) && (r_tog != 16'hFFFF)) r_tog <= r_tog + 16'd1;
            if (w_active && !w_tmo && (r_cyc != 32'hFFFF_FFFF)) r_cyc <= r_cyc + 32'd1;
            if (w_tmo) begin
                r_to <= 1'b1;
                r_ec <= '1;
            end else if ((r_state == EXIT) && uart_wr_valid) begin
                r_ec <= uart_wr_data;
            end
        end
    end

    assign dut_rst_n   = r_state != HOLD;
    assign rd_valid    = !w_empty;
    assign rd_data     = r_mem[r_rp[AW-1:0]];
    assign overflow    = r_ovf;
    assign led_toggles = r_tog;
    assign cycle_count = r_cyc;
    assign done        = r_state == DONE;
    assign timed_out   = r_to;
    assign exit_code   = r_ec;
endmodule

// File: tb/tb_tb_harness_ctrl.sv
// tb_tb_harness_ctrl: directed vectors plus a randomized run against a queue-based model;
// u0 has the timeout disabled, u1 uses TIMEOUT=50, both share the same stimulus.
module tb_tb_harness_ctrl;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst_n, wv, rdy;
    logic [7:0] wd;
    logic [0:0] led;

    logic        drn [2], rv [2], ovf [2], dn [2], tmo [2];
    logic [7:0]  rdd [2], ec [2];
    logic [15:0] tog [2];
    logic [31:0] cyc [2];

    always #5 clk = ~clk;

    tb_harness_ctrl #(.TIMEOUT(0)) u0 (
        .CLK(clk), .RST_N(rst_n), .dut_rst_n(drn[0]), .uart_wr_valid(wv), .uart_wr_data(wd),
        .led(led), .rd_valid(rv[0]), .rd_ready(rdy), .rd_data(rdd[0]), .overflow(ovf[0]),
        .led_toggles(tog[0]), .cycle_count(cyc[0]), .done(dn[0]), .timed_out(tmo[0]),
        .exit_code(ec[0])
    );

    tb_harness_ctrl #(.TIMEOUT(TO)) u1 (
        .CLK(clk), .RST_N(rst_n), .dut_rst_n(drn[1]), .uart_wr_valid(wv), .uart_wr_data(wd),
        .led(led), .rd_valid(rv[1]), .rd_ready(rdy), .rd_data(rdd[1]), .overflow(ovf[1]),
        .led_toggles(tog[1]), .cycle_count(cyc[1]), .done(dn[1]), .timed_out(tmo[1]),
        .exit_code(ec[1])
    );

    typedef struct {
        logic        wv;
        logic [7:0]  wd;
        logic        rdy;
        logic        v;
        logic [7:0]  d;
        logic        dn;
        logic        to;
        logic [7:0]  ec;
        logic [31:0] cyc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] bund(input int k);
        return {3'b0, drn[k], rv[k], ovf[k], dn[k], tmo[k], ec[k], tog[k], cyc[k]};
    endfunction

    // reset 3 cycles, release with bytes streaming in, return at the first RUN negedge
    task automatic do_reset();
        int n;
        rst_n = 1'b0; wv = 1'b0; rdy = 1'b0; led = 1'b0; wd = 8'h00;
        @(negedge clk);
        chk("reset_outs_u0", bund(0), 64'd0);
        chk("reset_outs_u1", bund(1), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; wv = 1'b1; wd = 8'($urandom);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (drn[0]) break;
            chk("hold_rd_valid", 64'(rv[0]), 64'd0);
            wd = 8'($urandom);
        end
        wv = 1'b0;
        chk("hold_len", 64'(n), 64'd10);
        chk("hold_bytes_dropped", 64'({drn[1], rv[0], rv[1]}), 64'h4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // behavioural reference for u1
    int         m_ph, m_hold;
    logic [7:0] m_q [$];
    logic       m_ovf, m_to, m_act, m_tm, m_pop, m_full, m_push;
    logic [7:0] m_ec;
    logic [15:0] m_tog;
    logic [31:0] m_cyc;
    logic [0:0] m_led;

    initial begin
        vec_t tbl [8];
        int   n, rdy_pct;
        tbl[0] = '{1'b1, 8'h4F, 1'b1, 1'b1, 8'h4F, 1'b0, 1'b0, 8'h00, 32'd1};
        tbl[1] = '{1'b1, 8'h4B, 1'b1, 1'b1, 8'h4B, 1'b0, 1'b0, 8'h00, 32'd2};
        tbl[2] = '{1'b1, 8'h0A, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 8'h00, 32'd3};
        tbl[3] = '{1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd4};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd5};
        tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd6};
        tbl[6] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd6};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd6};

        rst_n = 1'b0; wv = 1'b0; rdy = 1'b0; led = 1'b0; wd = 8'h00;
        @(negedge clk);

        // reset sequencing followed by the normal-exit table on u0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wv = tbl[i].wv; wd = tbl[i].wd; rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("exit_vec%0d", i),
                64'({rv[0], tbl[i].v ? rdd[0] : 8'h00, dn[0], tmo[0], ec[0], cyc[0]}),
                64'({tbl[i].v, tbl[i].d, tbl[i].dn, tbl[i].to, tbl[i].ec, tbl[i].cyc}));
        end
        wv = 1'b0;

        // overflow: 17 pushes into a 16-deep FIFO, then drain
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wv = 1'b1; wd = 8'(8'h10 + i);
            @(negedge clk);
        end
        wv = 1'b0;
        chk("ovf_set", 64'({ovf[0], rv[0]}), 64'h3);
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain", 64'({rv[0], rdd[0]}), 64'({1'b1, 8'(8'h10 + i)}));
            @(negedge clk);
        end
        chk("ovf_empty_sticky", 64'({rv[0], ovf[0]}), 64'h1);

        // full FIFO with simultaneous push and pop must not overflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wv = 1'b1; wd = 8'(8'h30 + i);
            @(negedge clk);
        end
        chk("full_no_ovf", 64'({ovf[0], rv[0], rdd[0]}), 64'h130);
        wd = 8'h40; rdy = 1'b1;
        @(negedge clk);
        wv = 1'b0;
        chk("push_pop_full", 64'(ovf[0]), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk("pp_drain", 64'({rv[0], rdd[0]}), 64'({1'b1, (i < 15) ? 8'(8'h31 + i) : 8'h40}));
            @(negedge clk);
        end
        chk("pp_empty", 64'({rv[0], ovf[0]}), 64'd0);

        // timeout on u1; u0 has it disabled
        do_reset();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (dn[1]) break;
        end
        chk("timeout_latency", 64'(n), 64'd51);
        chk("timeout_outs", 64'({dn[1], tmo[1], ec[1], cyc[1]}), 64'({1'b1, 1'b1, 8'hFF, 32'd50}));
        repeat (5) @(negedge clk);
        chk("timeout_frozen", 64'({dn[1], cyc[1]}), 64'({1'b1, 32'd50}));
        chk("timeout_disabled", 64'({dn[0], tmo[0]}), 64'd0);

        // LED toggles, then mid-test reset with bytes queued
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) led = ~led;
            @(negedge clk);
        end
        chk("led_toggles", 64'(tog[0]), 64'd10);
        for (int i = 0; i < 3; i++) begin
            wv = 1'b1; wd = 8'(8'h60 + i);
            @(negedge clk);
        end
        wv = 1'b0; led = 1'b1;
        chk("pre_reset_full", 64'(rv[0]), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midtest_reset_u0", bund(0), 64'd0);
        chk("midtest_reset_u1", bund(1), 64'd0);

        // randomized run of u1 against the model
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(0, 100);
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            wv    = $urandom_range(0, 1) == 0;
            wd    = ($urandom_range(0, 19) == 0) ? 8'h04 : 8'($urandom);
            rdy   = $urandom_range(0, 99) < rdy_pct;
            if ($urandom_range(0, 3) == 0) led = ~led;
            @(posedge clk);
            if (!rst_n) begin
                m_ph = 0; m_hold = 0; m_q.delete(); m_ovf = 0; m_to = 0;
                m_ec = 8'h00; m_tog = 16'h0; m_cyc = 32'h0; m_led = 1'b0;
            end else begin
                m_act  = (m_ph == 1) || (m_ph == 2);
                m_tm   = m_act && (m_cyc == 32'(TO));
                m_pop  = (m_q.size() != 0) && rdy;
                m_full = m_q.size() == 16;
                m_push = (m_ph == 1) && wv && (wd != 8'h04) && !m_tm;
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    if (!m_full || m_pop) m_q.push_back(wd);
                    else m_ovf = 1'b1;
                end
                if (m_act && (led != m_led) && (m_tog != 16'hFFFF)) m_tog = m_tog + 16'd1;
                m_led = led;
                if (m_act && !m_tm && (m_cyc != 32'hFFFF_FFFF)) m_cyc = m_cyc + 32'd1;
                if (m_ph == 0) begin
                    m_hold++;
                    if (m_hold == 10) m_ph = 1;
                end else if (m_act && m_tm) begin
                    m_ph = 3; m_to = 1'b1; m_ec = 8'hFF;
                end else if (m_ph == 1) begin
                    if (wv && (wd == 8'h04)) m_ph = 2;
                end else if (m_ph == 2) begin
                    if (wv) begin
                        m_ec = wd; m_ph = 3;
                    end
                end
            end
            @(negedge clk);
            chk($sformatf("rand_c%0d", c), bund(1),
                {3'b0, m_ph != 0, m_q.size() != 0, m_ovf, m_ph == 3, m_to, m_ec, m_tog, m_cyc});
            if (m_q.size() != 0) chk($sformatf("rand_data_c%0d", c), 64'(rdd[1]), 64'(m_q[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tb_harness_ctrl.md
TB_HARNESS_CTRL -- requirements
Module: tb_harness_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8: UART byte width.
- FIFO_DEPTH, 16: capture FIFO entries; power of 2, at least 2.
- N_LED, 1: number of LED inputs monitored.
- RST_HOLD, 10: cycles the DUT is held in reset after RST_N deasserts; at least 1.
- TIMEOUT, 1000000: run-cycle limit; 0 disables the timeout.
- EOT_CHAR, 8'h04: end-of-test marker byte.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: single clock; all state updates on its rising edge.
- RST_N, in, 1: reset, synchronous, active-low.
- dut_rst_n, out, 1: sequenced reset driven to the DUT.
- uart_wr_valid, in, 1: DUT UART byte strobe.
- uart_wr_data, in, DATA_W: DUT UART byte.
- led, in, N_LED: DUT LED outputs.
- rd_valid, out, 1: capture FIFO non-empty.
- rd_ready, in, 1: consumer accepts the head byte.
- rd_data, out, DATA_W: capture FIFO head byte.
- overflow, out, 1: sticky flag; a byte was dropped.
- led_toggles, out, 16: count of LED-change cycles.
- cycle_count, out, 32: DUT run cycles.
- done, out, 1: test finished.
- timed_out, out, 1: test ended by timeout.
- exit_code, out, DATA_W: byte following EOT_CHAR, or all-ones on timeout.

Function
REQ-003 The FSM SHALL have states HOLD, RUN, EXIT, DONE; RST_N low forces HOLD.
REQ-004 HOLD SHALL drive dut_rst_n=0 and count cycles with RST_N high.
- After RST_HOLD such cycles: dut_rst_n=1 from the next cycle, and the FSM moves to RUN.
REQ-005 While dut_rst_n=0, uart_wr_valid and led SHALL be ignored.
REQ-006 In RUN, a valid byte equal to EOT_CHAR SHALL move the FSM to EXIT and SHALL NOT be pushed to the FIFO.
REQ-007 In RUN, any other valid byte SHALL be pushed to the FIFO.
REQ-008 In EXIT, the next valid byte SHALL be latched into exit_code; done=1 from the following cycle (state DONE); that byte is not pushed.
REQ-009 In DONE, the block SHALL ignore UART input, freeze cycle_count and led_toggles, keep dut_rst_n=1, and remain there until RST_N is low.
REQ-010 cycle_count SHALL increment each cycle in RUN or EXIT and saturate at 2^32-1.
REQ-011 If TIMEOUT != 0 and cycle_count == TIMEOUT in RUN or EXIT, the next state SHALL be DONE with timed_out=1 and exit_code=all-ones.
- Timeout has priority over a same-cycle UART byte; that byte is dropped and overflow is unaffected.
REQ-012 The FIFO SHALL be show-ahead: rd_valid = not empty, rd_data = head.
- Pop on rd_valid && rd_ready.
- A byte pushed in cycle t is visible no earlier than t+1.
REQ-013 A push with the FIFO full and no same-cycle pop SHALL drop the byte and set overflow (sticky until reset).
- A push and pop in the same cycle when full SHALL both succeed.
REQ-014 rd_ready with the FIFO empty SHALL have no effect; pointers wrap modulo FIFO_DEPTH.
REQ-015 The FIFO SHALL remain drainable in every state except during reset.
REQ-016 led SHALL be registered each cycle.
- In RUN or EXIT, led_toggles increments (saturating at 16'hFFFF) in any cycle where led differs from its registered value.

Reset
REQ-017 On RST_N low at a clock edge, including mid-test, the block SHALL set:
- state=HOLD, hold counter=0, dut_rst_n=0;
- FIFO empty, rd_valid=0, overflow=0;
- cycle_count=0, led_toggles=0;
- done=0, timed_out=0, exit_code=0;
- registered led=0.
REQ-018 Every output SHALL equal its reset value in the first cycle after reset is applied.

Verification
REQ-019 Reset sequencing:
- RST_N low 3 cycles, then high.
- Required: dut_rst_n=0 for exactly RST_HOLD=10 cycles after release, then 1.
- Required: UART bytes sent during the hold never appear on rd_valid.
REQ-020 Normal exit:
- Send "OK\n", then 8'h04, then 8'h00; hold rd_ready=1.
- Required: rd_data sequence 8'h4F, 8'h4B, 8'h0A.
- Required: done=1, exit_code=8'h00, timed_out=0.
REQ-021 Overflow:
- rd_ready=0; push 17 bytes with FIFO_DEPTH=16.
- Required: overflow=1; the 16 drained bytes are the first 16 sent.
- Repeat with a same-cycle push and pop while full: required overflow stays 0.
REQ-022 Timeout:
- TIMEOUT=50, no EOT sent.
- Required: done=1, timed_out=1, exit_code=8'hFF, cycle_count=50 and frozen.
REQ-023 LED and mid-test reset:
- Toggle led[0] every 4 cycles for 40 cycles.
- Required: led_toggles=10.
- Then assert RST_N low mid-RUN: required all outputs at reset values on the next cycle, and the FIFO empty.
